// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals for the shared memory port arbiter.
// slave = arbiter side; master = requesters plus memory macro.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin fetch/data arbiter for one single-port memory: gnt+mem_en 1 cycle after req, completion MEM_LAT later (writes: 1).
// One transaction in flight; requesters hold req until gnt, new arbitration only from IDLE.
module mem_port_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_gnt_q, last_gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic              winner;

  // On a tie the port that did not win last time goes next.
  assign winner = (bus.f_req && bus.d_req) ? ~last_gnt_q : bus.d_req;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_cnt_d  = lat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.f_req || bus.d_req) begin
          owner_d    = winner;
          last_gnt_d = winner;
          we_d       = (winner == OWN_D) && bus.d_we;
          addr_d     = (winner == OWN_D) ? bus.d_addr : bus.f_addr;
          wdata_d    = (winner == OWN_D) ? bus.d_wdata : '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q || (MEM_LAT == 1)) begin
          state_d = S_DONE;
        end else begin
          lat_cnt_d = LAT_LOAD;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_F;
      last_gnt_q <= OWN_D;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_cnt_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

  assign bus.f_gnt     = (state_q == S_ISSUE) && (owner_q == OWN_F);
  assign bus.d_gnt     = (state_q == S_ISSUE) && (owner_q == OWN_D);
  assign bus.f_rvalid  = (state_q == S_DONE) && (owner_q == OWN_F);
  assign bus.d_ack     = (state_q == S_DONE) && (owner_q == OWN_D);
  assign bus.f_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign bus.mem_en    = (state_q == S_ISSUE);
  assign bus.mem_we    = (state_q == S_ISSUE) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous memory between the instruction-fetch requester (read-only) and the data load/store requester (read/write). Requests use a req/gnt handshake and are arbitrated round-robin, with one outstanding memory transaction at a time. Read data returns after a fixed, parameterised memory latency. The block sits between the control unit's imem_read/dmem_read/dmem_write sequencing and a unified memory macro.

Parameters:
DATA_W, 16, data bus width (matches processor BUS_WIDTH)
ADDR_W, 8, memory address width
MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high reset
f_req  input  1  fetch request; held high with f_addr stable until f_gnt
f_addr  input  ADDR_W  fetch address
f_gnt  output  1  one-cycle pulse: fetch accepted
f_rvalid  output  1  one-cycle pulse: f_rdata valid
f_rdata  output  DATA_W  fetch read data (= mem_rdata)
d_req  input  1  data request; d_we/d_addr/d_wdata held stable until d_gnt
d_we  input  1  1 = write, 0 = read
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  write data
d_gnt  output  1  one-cycle pulse: data request accepted
d_ack  output  1  one-cycle pulse: read data valid, or write complete
d_rdata  output  DATA_W  data read data (= mem_rdata)
mem_en  output  1  memory access strobe, one cycle per transaction
mem_we  output  1  memory write enable, qualified by mem_en
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  output  1  high in every state except IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Reset sets state=IDLE, last_gnt=DATA, lat_cnt=0, and every registered output to 0.
- IDLE: at the edge where f_req or d_req is sampled high, latch the winner (owner, we, addr, wdata) and go to ISSUE. With no request, remain in IDLE.
- Arbitration: with a single requester, that requester wins. With both requesting, the port opposite to last_gnt wins. last_gnt updates when the winner is latched. After reset, a tie goes to fetch.
- ISSUE (1 cycle): mem_en=1; mem_we=owner_we (always 0 for fetch); mem_addr and mem_wdata come from the latched values; the owner's gnt=1.
  - Write, or read with MEM_LAT=1: go to DONE.
  - Otherwise: load lat_cnt=MEM_LAT-1 and go to WAIT.
- WAIT: decrement lat_cnt each cycle; go to DONE when lat_cnt reaches 1. All mem_* strobes are 0.
- DONE (1 cycle): pulse the owner's completion signal (f_rvalid for a fetch, d_ack for a data access). Return to IDLE. New arbitration happens only in IDLE.
- Timing for requests first sampled at edge T:
  - gnt and mem_en are high in cycle T+1.
  - Read completion pulse is in cycle T+1+MEM_LAT.
  - Write completion pulse (d_ack) is in cycle T+2.
- f_rdata and d_rdata are combinational copies of mem_rdata. They are meaningful only when the matching valid/ack pulse is high.
- Requester deasserting req before gnt is a protocol violation. The latched transaction still completes.
- A requester holding req high after its completion is treated as a new request at the next IDLE.
- Never more than one outstanding access. gnt/rvalid/ack never fire for the non-owner.
- Fairness: with both requesters continuously asserted, grants strictly alternate. No port waits more than one foreign transaction.
- reset asserted in any state (including WAIT/ISSUE) abandons the transaction: no completion pulse is issued, mem_en=0 on the next cycle, and state is IDLE.

Test Plan:
- MEM_LAT=1: f_req at T with f_addr=0x10, mem[0x10]=0xA5C3 -> f_gnt and mem_en with mem_addr=0x10 at T+1; f_rvalid with f_rdata=0xA5C3 at T+2; busy low at T+3.
- d_req, d_we=1, d_addr=0x20, d_wdata=0x1234 -> mem_we=1 at T+1, d_ack at T+2. Then a data read of 0x20 -> d_ack with d_rdata=0x1234.
- f_req and d_req both held high from reset -> grant order F,D,F,D. Each fetch returns correct data; no gnt overlap.
- MEM_LAT=3: data read at T -> d_gnt at T+1, mem_en high only at T+1, d_ack at T+4, next grant at T+6 if a request is pending.
- MEM_LAT=3: assert reset during WAIT -> no d_ack, busy=0 and all strobes 0 after the reset edge. A later fetch completes normally.
- Fetch request only, d_req=0 for 10 transactions -> fetch granted back-to-back; d_gnt and d_ack stay 0.
